// File: rtl/pc_sequencer.sv
// Fetch-stage program counter sequencer: holds and steps the PC, and resolves
// branch/call/return through an external branch-target LUT and a circular return-address stack.
module pc_sequencer #(
  parameter int D         = 10,
  parameter int LUT_AW    = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic              halt_en,
  input  logic [LUT_AW-1:0] lut_idx,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [D-1:0]      lut_target,
  output logic [D-1:0]      pc,
  output logic              running,
  output logic              done,
  output logic              ras_err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

  state_e          state_q, state_d;
  logic [D-1:0]    pc_q, pc_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [PW-1:0]   sp_q, sp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [D-1:0]    stack_q [RAS_DEPTH];
  logic [D-1:0]    stack_d [RAS_DEPTH];
  logic [D-1:0]    pc_inc;

  assign lut_addr = lut_idx;
  assign pc_inc   = pc_q + D'(1);

  // sp_q points at the next free slot; a full-stack push lands on the oldest entry.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    err_d   = err_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    stack_d = stack_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          sp_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt_en) begin
            state_d = HALTED;
            done_d  = 1'b1;
          end else if (ret_en) begin
            if (cnt_q != '0) begin
              pc_d  = stack_q[sp_q - PW'(1)];
              sp_d  = sp_q - PW'(1);
              cnt_d = cnt_q - CW'(1);
            end else begin
              err_d   = 1'b1;
              state_d = HALTED;
              done_d  = 1'b1;
            end
          end else if (call_en) begin
            stack_d[sp_q] = pc_inc;
            sp_d          = sp_q + PW'(1);
            if (cnt_q == CW'(RAS_DEPTH)) err_d = 1'b1;
            else                         cnt_d = cnt_q + CW'(1);
            pc_d = lut_target;
          end else if (branch_en) begin
            pc_d = lut_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sp_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      stack_q <= stack_d;
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == RUN);
  assign done    = done_q;
  assign ras_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural branch-target LUT.
module tb_pc_sequencer;
  localparam int D = 10, LUT_AW = 8, RAS_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, stall, branch_en, call_en, ret_en, halt_en;
  logic [LUT_AW-1:0] lut_idx, lut_addr;
  logic [D-1:0]      lut_target, pc;
  logic              running, done, ras_err;
  int checks = 0, failures = 0;

  pc_sequencer #(.D(D), .LUT_AW(LUT_AW), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
    .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en), .halt_en(halt_en),
    .lut_idx(lut_idx), .lut_addr(lut_addr), .lut_target(lut_target),
    .pc(pc), .running(running), .done(done), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] lut_fn(input logic [LUT_AW-1:0] a);
    case (a)
      8'd2:    return 10'd285;
      8'd5:    return 10'd1022;
      8'd7:    return 10'd10;
      8'd16:   return 10'd35;
      8'd20:   return 10'd42;
      default: return D'(a * 3 + 100);
    endcase
  endfunction

  always_comb lut_target = lut_fn(lut_addr);

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clr;
    start = 0; stall = 0; branch_en = 0; call_en = 0; ret_en = 0; halt_en = 0; lut_idx = '0;
  endtask

  task automatic restart;
    clr(); reset_n = 0; tick(); reset_n = 1; start = 1; tick(); start = 0;
  endtask

  task automatic test_reset;
    clr(); reset_n = 0; #12;
    checks++; if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0 || ras_err !== 1'b0) begin
      failures++; $display("FAIL reset_state pc=%0d run=%b done=%b err=%b want 0/0/0/0", pc, running, done, ras_err); end
    tick(); reset_n = 1; branch_en = 1; lut_idx = 8'd2; tick(); tick();
    checks++; if (pc !== 10'd0 || running !== 1'b0) begin
      failures++; $display("FAIL idle_ignore pc=%0d run=%b want 0/0", pc, running); end
    clr();
  endtask

  task automatic test_sequential;
    start = 1; tick(); start = 0;
    checks++; if (pc !== 10'd0 || running !== 1'b1) begin
      failures++; $display("FAIL start pc=%0d run=%b want 0/1", pc, running); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (pc !== D'(i) || running !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL seq_step pc=%0d run=%b done=%b want %0d/1/0", pc, running, done, i); end
    end
  endtask

  task automatic test_branch;
    restart(); tick(); tick(); tick();
    stall = 1; branch_en = 1; lut_idx = 8'd2; #1;
    checks++; if (lut_addr !== 8'd2) begin
      failures++; $display("FAIL lut_addr got=%0d want 2", lut_addr); end
    tick();
    checks++; if (pc !== 10'd3) begin
      failures++; $display("FAIL branch_stall pc=%0d want 3", pc); end
    stall = 0; tick(); clr();
    checks++; if (pc !== 10'd285) begin
      failures++; $display("FAIL branch pc=%0d want 285", pc); end
  endtask

  task automatic test_back_to_back;
    restart(); branch_en = 1; lut_idx = 8'd7; tick(); clr();
    call_en = 1; lut_idx = 8'd16; tick(); clr();
    checks++; if (pc !== 10'd35) begin
      failures++; $display("FAIL call pc=%0d want 35", pc); end
    ret_en = 1; tick(); clr();
    checks++; if (pc !== 10'd11) begin
      failures++; $display("FAIL ret pc=%0d want 11", pc); end
    call_en = 1; branch_en = 1; lut_idx = 8'd16; tick(); clr();
    ret_en = 1; tick(); clr();
    checks++; if (pc !== 10'd12 || running !== 1'b1) begin
      failures++; $display("FAIL call_over_branch pc=%0d run=%b want 12/1", pc, running); end
  endtask

  task automatic test_overflow;
    logic [D-1:0] exp_ret [4] = '{10'd200, 10'd197, 10'd194, 10'd191};
    restart();
    for (int i = 0; i < 5; i++) begin
      call_en = 1; lut_idx = LUT_AW'(30 + i); tick(); clr();
      checks++; if (pc !== D'(190 + 3 * i) || ras_err !== (i == 4)) begin
        failures++; $display("FAIL call_%0d pc=%0d err=%b want %0d/%b", i, pc, ras_err, 190 + 3 * i, i == 4); end
    end
    for (int i = 0; i < 4; i++) begin
      ret_en = 1; tick(); clr();
      checks++; if (pc !== exp_ret[i] || running !== 1'b1) begin
        failures++; $display("FAIL unwind_%0d pc=%0d run=%b want %0d/1", i, pc, running, exp_ret[i]); end
    end
    ret_en = 1; tick(); clr();
    checks++; if (pc !== 10'd191 || running !== 1'b0 || done !== 1'b1 || ras_err !== 1'b1) begin
      failures++; $display("FAIL underflow pc=%0d run=%b done=%b err=%b want 191/0/1/1", pc, running, done, ras_err); end
    tick();
    checks++; if (done !== 1'b0 || ras_err !== 1'b1) begin
      failures++; $display("FAIL underflow_done_pulse done=%b err=%b want 0/1", done, ras_err); end
  endtask

  task automatic test_restart;
    start = 1; tick();
    checks++; if (pc !== 10'd0 || running !== 1'b1 || ras_err !== 1'b0) begin
      failures++; $display("FAIL restart pc=%0d run=%b err=%b want 0/1/0", pc, running, ras_err); end
    tick(); clr();
    checks++; if (pc !== 10'd1) begin
      failures++; $display("FAIL start_in_run pc=%0d want 1", pc); end
  endtask

  task automatic test_halt;
    restart(); branch_en = 1; lut_idx = 8'd20; tick(); clr();
    stall = 1; halt_en = 1; tick();
    checks++; if (pc !== 10'd42 || running !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL halt_stall pc=%0d run=%b done=%b want 42/1/0", pc, running, done); end
    stall = 0; tick(); clr();
    checks++; if (pc !== 10'd42 || running !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL halt pc=%0d run=%b done=%b want 42/0/1", pc, running, done); end
    tick();
    checks++; if (pc !== 10'd42 || done !== 1'b0) begin
      failures++; $display("FAIL halt_done_pulse pc=%0d done=%b want 42/0", pc, done); end
  endtask

  task automatic test_async_reset;
    restart(); tick(); tick();
    #2; reset_n = 0; #1;
    checks++; if (pc !== 10'd0 || running !== 1'b0) begin
      failures++; $display("FAIL async_reset pc=%0d run=%b want 0/0", pc, running); end
    tick(); reset_n = 1;
  endtask

  task automatic test_wrap;
    restart(); branch_en = 1; lut_idx = 8'd5; tick(); clr();
    checks++; if (pc !== 10'd1022) begin
      failures++; $display("FAIL wrap_setup pc=%0d want 1022", pc); end
    tick();
    checks++; if (pc !== 10'd1023) begin
      failures++; $display("FAIL wrap_top pc=%0d want 1023", pc); end
    tick();
    checks++; if (pc !== 10'd0) begin
      failures++; $display("FAIL wrap_zero pc=%0d want 0", pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_back_to_back();
    test_overflow();
    test_restart();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
